// File: rtl/aes256_key_expand.sv
// aes256_key_expand: streams the 15 AES-256 round keys of a cipher key over a valid/ready port.
// Optional AES256_KEY_EXPAND_ABORT_EN adds an abort input that cancels a running expansion.
module aes256_key_expand_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    logic [7:0] sq, inv;
    // multiplicative inverse as a^254 by repeated squaring, then the affine map
    always_comb begin
        sq = a_i;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes256_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [255:0] key_in,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
`ifdef AES256_KEY_EXPAND_ABORT_EN
    input  logic         abort,
`endif
    output logic         done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    logic [0:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [255:0] win_q, win_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;
    logic         abort_w, hs, even;
    logic [31:0]  sub_in, sub_out, w0, w1, w2, w3;
`ifdef AES256_KEY_EXPAND_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif
    // win_q holds the two most recent round keys {prev2, prev1}
    assign key_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rk_valid  = state_q == EMIT;
    assign rk_idx    = idx_q;
    assign rk_out    = idx_q == 4'd0 ? win_q[255:128] : win_q[127:0];
    assign done      = done_q;
    assign hs        = rk_valid && rk_ready;
    assign even      = idx_q[0];
    assign sub_in    = even ? {win_q[23:0], win_q[31:24]} : win_q[31:0];
    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        aes256_key_expand_sbox u_sbox (.a_i(sub_in[8*g +: 8]), .s_o(sub_out[8*g +: 8]));
    end
    assign w0 = win_q[255:224] ^ sub_out ^ (even ? {rcon_q, 24'h0} : 32'h0);
    assign w1 = win_q[223:192] ^ w0;
    assign w2 = win_q[191:160] ^ w1;
    assign w3 = win_q[159:128] ^ w2;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (key_valid) begin
                state_d = EMIT;
                idx_d   = 4'd0;
                win_d   = key_in;
                rcon_d  = 8'h01;
            end
        end else if (abort_w) begin
            state_d = IDLE;
        end else if (hs) begin
            if (idx_q == 4'd14) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
                win_d = idx_q == 4'd0 ? win_q : {win_q[127:0], w0, w1, w2, w3};
                // the final Rcon (8'h40) is not advanced past
                rcon_d = (idx_q != 4'd0 && even && idx_q != 4'd13) ? {rcon_q[6:0], 1'b0} : rcon_q;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            win_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: scoreboard bench for aes256_key_expand using a FIPS-197 key schedule model.
module tb_aes256_key_expand;
    localparam logic [255:0] A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, rk_ready = 1'b0;
    logic [255:0] key_in = '0;
    logic key_ready, rk_valid, busy, done;
    logic [3:0] rk_idx;
    logic [127:0] rk_out;
`ifdef AES256_KEY_EXPAND_ABORT_EN
    logic abort = 1'b0;
`endif
    typedef struct packed {logic [3:0] idx; logic [127:0] rk;} exp_t;
    exp_t sb_q[$];
    exp_t e;
    logic [127:0] got [15];
    logic [127:0] last_rk = '0, held_rk = '0;
    logic [3:0] held_idx = '0;
    logic stalled = 1'b0;
    int checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    aes256_key_expand dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk_out(rk_out), .busy(busy),
`ifdef AES256_KEY_EXPAND_ABORT_EN
        .abort(abort),
`endif
        .done(done));

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, want);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[2047 - 8*int'(w[8*i +: 8]) -: 8];
        return r;
    endfunction

    task automatic push_expected(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) sb_q.push_back('{idx: 4'(r), rk: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && rk_valid) begin
            if (stalled) begin
                check("stall_idx", 128'(rk_idx), 128'(held_idx));
                check("stall_rk", rk_out, held_rk);
            end
            if (rk_ready) begin
                hs_cnt++;
                got[rk_idx] = rk_out;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    last_rk = e.rk;
                    check("rk_idx", 128'(rk_idx), 128'(e.idx));
                    check("rk_out", rk_out, e.rk);
                end else begin
                    check("sb_underflow", 128'(sb_q.size()), 128'd1);
                end
            end
        end
        stalled = rst_n && rk_valid && !rk_ready;
        held_idx = rk_idx;
        held_rk = rk_out;
    end

    task automatic load_key(input logic [255:0] k);
        check("key_ready_idle", 128'(key_ready), 128'd1);
        key_valid = 1'b1;
        key_in = k;
        push_expected(k);
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    // mode 0: ready held, 1: random ready with stall at rk 7, 2: key pulse at rk 4, 3: reset at rk 9, 4: abort at rk 3
    task automatic run(input int mode);
        int cyc = 0, stall = 0;
        bit s7 = 0, pulsed = 0;
        hs_cnt = 0;
        done_cnt = 0;
        rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            @(posedge clk);
            #1 cyc++;
            if (done || cyc > 400) break;
            if (mode == 0 && cyc == 14) check("lat_idx14", {123'd0, rk_valid, rk_idx}, {123'd0, 1'b1, 4'd14});
            if (mode == 2) begin
                check("key_ready_busy", 128'(key_ready), 128'd0);
                key_valid = rk_idx == 4'd4 && !pulsed;
                key_in = {8{32'hdeadbeef}};
                pulsed = pulsed || key_valid;
            end
            if (mode == 3 && rk_idx == 4'd9) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_rk_valid", 128'(rk_valid), 128'd0);
                check("rst_busy", 128'(busy), 128'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk);
                #1 check("rst_no_done", 128'(done_cnt), 128'd0);
                sb_q.delete();
                return;
            end
`ifdef AES256_KEY_EXPAND_ABORT_EN
            if (mode == 4 && rk_idx == 4'd3) begin
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                check("abort_rk_valid", 128'(rk_valid), 128'd0);
                check("abort_key_ready", 128'(key_ready), 128'd1);
                @(posedge clk);
                #1 check("abort_no_done", 128'(done_cnt), 128'd0);
                sb_q.delete();
                return;
            end
`endif
            if (mode == 1) begin
                if (rk_valid && rk_idx == 4'd7 && !s7) begin
                    s7 = 1;
                    stall = 5;
                end
                rk_ready = stall > 0 ? 1'b0 : 1'($urandom_range(0, 1));
                if (stall > 0) stall--;
            end
        end
        check("done_seen", 128'(done), 128'd1);
        if (mode == 0) check("latency", 128'(cyc), 128'd15);
        @(posedge clk);
        #1 check("done_pulse", 128'(done), 128'd0);
        check("idle_rk_valid", 128'(rk_valid), 128'd0);
        check("idle_key_ready", 128'(key_ready), 128'd1);
        check("idle_hold", rk_out, last_rk);
        @(posedge clk);
        #1 check("done_count", 128'(done_cnt), 128'd1);
        check("hs_count", 128'(hs_cnt), 128'd15);
        check("sb_drained", 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 load_key(A3);
        run(0);
        check("a3_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        check("a3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
        load_key('0);
        run(0);
        check("zero_rk0", got[0], 128'd0);
        check("zero_rk1", got[1], 128'd0);
        check("zero_rk2", got[2], 128'h62636363626363636263636362636363);
        check("zero_rk3", got[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
        load_key(A3);
        run(1);
        rk_ready = 1'b1;
        load_key(A3);
        run(2);
        load_key(A3);
        run(3);
        load_key(A3);
        run(0);
        check("rerun_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
`ifdef AES256_KEY_EXPAND_ABORT_EN
        load_key(A3);
        run(4);
        load_key(A3);
        run(0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
